// File: rtl/div3_pkg.sv
// ============================================================================
// Module  : div3_pkg
// Brief   : Shared types and the radix-2/radix-4 divide-by-3 digit function.
//           Macro DIV3_RADIX4_EN selects 2 dividend bits per digit step.
// Revision: 1.0
// ============================================================================
`default_nettype none

package div3_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef logic [1:0] rem_t;

    localparam rem_t REM0 = 2'd0;
    localparam rem_t REM1 = 2'd1;
    localparam rem_t REM2 = 2'd2;

`ifdef DIV3_RADIX4_EN
    localparam int c_digit_w = 2;
`else
    localparam int c_digit_w = 1;
`endif

    // Returns {q, rem}; t = rem*2^c_digit_w + bits never exceeds 11.
    function automatic logic [c_digit_w+1:0] div3_digit(input rem_t rem,
                                                        input logic [c_digit_w-1:0] bits);
        logic [3:0] t;
        logic [3:0] m;
        logic [1:0] q;
        rem_t       r;
        r = (rem == 2'd3) ? REM0 : rem;
        t = 4'({r, bits});
        if (t >= 4'd9)      q = 2'd3;
        else if (t >= 4'd6) q = 2'd2;
        else if (t >= 4'd3) q = 2'd1;
        else                q = 2'd0;
        m = 4'({q, 1'b0}) + 4'(q);
        r = rem_t'(t - m);
        return {q[c_digit_w-1:0], r};
    endfunction

endpackage

`default_nettype wire

// File: rtl/div3_step.sv
// ============================================================================
// Module  : div3_step
// Brief   : One combinational divide-by-3 digit step (width set by DIV3_RADIX4_EN).
// Revision: 1.0
// ============================================================================
`default_nettype none

module div3_step
    import div3_pkg::*;
(
    input  rem_t                 rem_in,
    input  logic [c_digit_w-1:0] bits_in,
    output logic [c_digit_w-1:0] q,
    output rem_t                 rem_out
);

    logic [c_digit_w+1:0] w_res;

    assign w_res   = div3_digit(rem_in, bits_in);
    assign q       = w_res[c_digit_w+1:2];
    assign rem_out = w_res[1:0];

endmodule

`default_nettype wire

// File: rtl/div3_serial.sv
// ============================================================================
// Module  : div3_serial
// Brief   : Bit-serial MSB-first unsigned divide-by-3 with valid/ready ports.
//           Macro DIV3_RADIX4_EN consumes 2 bits per cycle (DATA_W must be even).
// Revision: 1.0
// ============================================================================
`default_nettype none

module div3_serial
    import div3_pkg::*;
#(
    parameter int DATA_W = 8
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_quot,
    output logic [1:0]        out_rem,
    output logic              out_div
);

    localparam int c_steps = DATA_W / c_digit_w;
    localparam int c_cnt_w = $clog2(DATA_W) + 1;

    generate
        if (DATA_W < 2) begin : g_bad_width
            $error("div3_serial: DATA_W must be >= 2");
        end
`ifdef DIV3_RADIX4_EN
        if (DATA_W % 2 != 0) begin : g_odd_width
            $error("div3_serial: DATA_W must be even when DIV3_RADIX4_EN is defined");
        end
`endif
    endgenerate

    state_t               r_state;
    state_t               w_state_nxt;
    logic [DATA_W-1:0]    r_shift;
    logic [DATA_W-1:0]    r_quot;
    rem_t                 r_rem;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [DATA_W-1:0]    r_out_quot;
    rem_t                 r_out_rem;
    logic                 r_out_div;

    logic                 w_last;
    logic [c_digit_w-1:0] w_bits;
    logic [c_digit_w-1:0] w_q;
    rem_t                 w_rem_nxt;
    logic [DATA_W-1:0]    w_quot_nxt;

    assign w_last     = (r_cnt == c_cnt_w'(1));
    assign w_bits     = r_shift[DATA_W-1 -: c_digit_w];
    assign w_quot_nxt = (r_quot << c_digit_w) | DATA_W'(w_q);

    div3_step u_step (
        .rem_in  (r_rem),
        .bits_in (w_bits),
        .q       (w_q),
        .rem_out (w_rem_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (in_valid)  w_state_nxt = RUN;
            RUN:     if (w_last)    w_state_nxt = DONE;
            DONE:    if (out_ready) w_state_nxt = IDLE;
            default:                w_state_nxt = IDLE;
        endcase
    end

    // Result registers load only on the final digit, so they hold through DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift    <= '0;
            r_quot     <= '0;
            r_rem      <= REM0;
            r_cnt      <= '0;
            r_out_quot <= '0;
            r_out_rem  <= REM0;
            r_out_div  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_shift <= in_data;
                        r_quot  <= '0;
                        r_rem   <= REM0;
                        r_cnt   <= c_cnt_w'(c_steps);
                    end
                end
                RUN: begin
                    r_shift <= r_shift << c_digit_w;
                    r_quot  <= w_quot_nxt;
                    r_rem   <= w_rem_nxt;
                    r_cnt   <= r_cnt - c_cnt_w'(1);
                    if (w_last) begin
                        r_out_quot <= w_quot_nxt;
                        r_out_rem  <= w_rem_nxt;
                        r_out_div  <= (w_rem_nxt == REM0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign out_quot  = r_out_quot;
    assign out_rem   = r_out_rem;
    assign out_div   = r_out_div;

endmodule

`default_nettype wire
